// File: rtl/loader_pkg.sv
// Shared constants and state encodings for the UART program loader.
package loader_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        WAIT_SYNC,
        LEN_HI,
        LEN_LO,
        DATA,
        DONE,
        ERROR
    } loader_state_t;

    typedef enum logic [1:0] {
        IDLE,
        START,
        BITS,
        STOP
    } rx_state_t;

endpackage

// File: rtl/uart_program_loader_if.sv
// Memory write port driven by the program loader.
interface uart_program_loader_if #(
    parameter int unsigned ADDR_WIDTH = 12
);
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [31:0]           mem_wdata;

    modport master (output mem_we, output mem_addr, output mem_wdata);
    modport slave  (input  mem_we, input  mem_addr, input  mem_wdata);
endinterface

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: input synchronizer, mid-bit sampling, glitch rejection.
module uart_rx_byte
    import loader_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_err
);

    localparam int unsigned CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

    logic          rx_meta, rx_sync, rx_prev;
    rx_state_t     state, state_d;
    logic [CW-1:0] cnt, cnt_d;
    logic [2:0]    bit_idx, bit_idx_d;
    logic [7:0]    shreg, shreg_d;
    logic          byte_valid_d, frame_err_d;

    assign byte_data = shreg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta    <= 1'b1;
            rx_sync    <= 1'b1;
            rx_prev    <= 1'b1;
            state      <= IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rx_meta    <= rx;
            rx_sync    <= rx_meta;
            rx_prev    <= rx_sync;
            state      <= state_d;
            cnt        <= cnt_d;
            bit_idx    <= bit_idx_d;
            shreg      <= shreg_d;
            byte_valid <= byte_valid_d;
            frame_err  <= frame_err_d;
        end
    end

    // Start bit is re-checked at its midpoint; later samples land mid-bit.
    always_comb begin
        state_d      = state;
        cnt_d        = cnt;
        bit_idx_d    = bit_idx;
        shreg_d      = shreg;
        byte_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        case (state)
            IDLE: begin
                if (rx_prev && !rx_sync) begin
                    state_d = START;
                    cnt_d   = '0;
                end
            end
            START: begin
                if (cnt == HALF_LAST) begin
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    state_d   = rx_sync ? IDLE : BITS;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            BITS: begin
                if (cnt == BIT_LAST) begin
                    cnt_d   = '0;
                    shreg_d = {rx_sync, shreg[7:1]};
                    if (bit_idx == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_idx_d = bit_idx + 3'd1;
                    end
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            STOP: begin
                if (cnt == BIT_LAST) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                    if (rx_sync) begin
                        byte_valid_d = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: rtl/uart_program_loader.sv
// Serial boot loader: parses a framed UART image and writes it into memory
// from address 0, holding the CPU in reset until the image is complete.
module uart_program_loader
    import loader_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 50_000_000,
    parameter int unsigned BAUD       = 115_200,
    parameter int unsigned ADDR_WIDTH = 12
) (
    input  logic                  external_clk,
    input  logic                  rst,
    input  logic                  rx,
    uart_program_loader_if.master mem,
    output logic                  cpu_hold,
    output logic                  load_done,
    output logic                  load_error,
    output logic [ADDR_WIDTH:0]   words_loaded
);

    localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int unsigned CNT_W        = ADDR_WIDTH + 1;
    localparam int unsigned MAX_WORDS    = 1 << ADDR_WIDTH;

    if (CLKS_PER_BIT < 4) begin : g_baud_check
        $error("uart_program_loader: CLK_FREQ/BAUD must be at least 4");
    end

    logic       byte_valid, frame_err;
    logic [7:0] rx_byte;

    uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk        (external_clk),
        .rst        (rst),
        .rx         (rx),
        .byte_valid (byte_valid),
        .byte_data  (rx_byte),
        .frame_err  (frame_err)
    );

    loader_state_t         state, state_d;
    logic [7:0]            len_hi, len_hi_d;
    logic [CNT_W-1:0]      len, len_d;
    logic [23:0]           word, word_d;
    logic [1:0]            byte_idx, byte_idx_d;
    logic [CNT_W-1:0]      words_loaded_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]           mem_wdata_q, mem_wdata_d;
    logic                  cpu_hold_d, load_done_d, load_error_d;
    logic [15:0]           n_words;

    assign mem.mem_we    = mem_we_q;
    assign mem.mem_addr  = mem_addr_q;
    assign mem.mem_wdata = mem_wdata_q;

    always_ff @(posedge external_clk or posedge rst) begin
        if (rst) begin
            state        <= WAIT_SYNC;
            len_hi       <= '0;
            len          <= '0;
            word         <= '0;
            byte_idx     <= '0;
            words_loaded <= '0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            cpu_hold     <= 1'b1;
            load_done    <= 1'b0;
            load_error   <= 1'b0;
        end else begin
            state        <= state_d;
            len_hi       <= len_hi_d;
            len          <= len_d;
            word         <= word_d;
            byte_idx     <= byte_idx_d;
            words_loaded <= words_loaded_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            cpu_hold     <= cpu_hold_d;
            load_done    <= load_done_d;
            load_error   <= load_error_d;
        end
    end

    // Image parser; DONE is entered on the edge that drops the final write strobe.
    always_comb begin
        state_d        = state;
        len_hi_d       = len_hi;
        len_d          = len;
        word_d         = word;
        byte_idx_d     = byte_idx;
        words_loaded_d = words_loaded;
        mem_we_d       = 1'b0;
        mem_addr_d     = mem_addr_q;
        mem_wdata_d    = mem_wdata_q;
        cpu_hold_d     = cpu_hold;
        load_done_d    = load_done;
        load_error_d   = load_error;
        n_words        = {len_hi, rx_byte};

        if (frame_err && state != DONE && state != ERROR) begin
            state_d      = ERROR;
            load_error_d = 1'b1;
        end else begin
            case (state)
                WAIT_SYNC: begin
                    if (byte_valid && rx_byte == SYNC_BYTE) state_d = LEN_HI;
                end
                LEN_HI: begin
                    if (byte_valid) begin
                        len_hi_d = rx_byte;
                        state_d  = LEN_LO;
                    end
                end
                LEN_LO: begin
                    if (byte_valid) begin
                        if (n_words == 16'd0) begin
                            state_d     = DONE;
                            cpu_hold_d  = 1'b0;
                            load_done_d = 1'b1;
                        end else if (32'(n_words) > MAX_WORDS) begin
                            state_d      = ERROR;
                            load_error_d = 1'b1;
                        end else begin
                            len_d      = CNT_W'(n_words);
                            byte_idx_d = '0;
                            state_d    = DATA;
                        end
                    end
                end
                DATA: begin
                    if (mem_we_q && words_loaded == len) begin
                        state_d     = DONE;
                        cpu_hold_d  = 1'b0;
                        load_done_d = 1'b1;
                    end else if (byte_valid) begin
                        if (byte_idx == 2'd3) begin
                            mem_we_d       = 1'b1;
                            mem_addr_d     = words_loaded[ADDR_WIDTH-1:0];
                            mem_wdata_d    = {word, rx_byte};
                            words_loaded_d = words_loaded + 1'b1;
                            byte_idx_d     = '0;
                        end else begin
                            word_d     = {word[15:0], rx_byte};
                            byte_idx_d = byte_idx + 2'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_program_loader.sv
// Scoreboard bench for uart_program_loader at 10 clocks per UART bit.
module tb_uart_program_loader;

    localparam int unsigned AW = 12;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          rx;
    logic          cpu_hold, load_done, load_error;
    logic [AW:0]   words_loaded;

    wr_t           exp_q[$];
    wr_t           e_mon;
    logic [7:0]    seq[$];
    logic          prev_we = 1'b0;
    int            n_cmp = 0;
    int            n_err = 0;

    uart_program_loader_if #(.ADDR_WIDTH(AW)) mem_if ();

    uart_program_loader #(
        .CLK_FREQ   (1_000_000),
        .BAUD       (100_000),
        .ADDR_WIDTH (AW)
    ) dut (
        .external_clk (clk),
        .rst          (rst),
        .rx           (rx),
        .mem          (mem_if),
        .cpu_hold     (cpu_hold),
        .load_done    (load_done),
        .load_error   (load_error),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe is matched against the expected-write queue.
    always @(negedge clk) begin
        if (!rst) begin
            if (mem_if.mem_we) begin
                check("no_back_to_back_we", 64'(prev_we), 64'd0);
                check("cpu_hold_during_write", 64'(cpu_hold), 64'd1);
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_write: addr %0h data %0h, expected no write",
                             mem_if.mem_addr, mem_if.mem_wdata);
                end else begin
                    e_mon = exp_q.pop_front();
                    check("write_addr", 64'(mem_if.mem_addr), 64'(e_mon.addr));
                    check("write_data", 64'(mem_if.mem_wdata), 64'(e_mon.data));
                end
            end
            prev_we = mem_if.mem_we;
        end else begin
            prev_we = 1'b0;
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        rx  = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_mem_we", 64'(mem_if.mem_we), 64'd0);
        check("rst_mem_addr", 64'(mem_if.mem_addr), 64'd0);
        check("rst_mem_wdata", 64'(mem_if.mem_wdata), 64'd0);
        check("rst_cpu_hold", 64'(cpu_hold), 64'd1);
        check("rst_load_done", 64'(load_done), 64'd0);
        check("rst_load_error", 64'(load_error), 64'd0);
        check("rst_words_loaded", 64'(words_loaded), 64'd0);
        exp_q.delete();
        rst = 1'b0;
        repeat (5) @(posedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        repeat (10) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (10) @(posedge clk);
        end
        rx = stop_bit;
        repeat (10) @(posedge clk);
        rx = 1'b1;
    endtask

    task automatic send_seq();
        for (int i = 0; i < seq.size(); i++) send_byte(seq[i], 1'b1);
    endtask

    task automatic push_write(input logic [AW-1:0] a, input logic [31:0] d);
        wr_t w;
        w.addr = a;
        w.data = d;
        exp_q.push_back(w);
    endtask

    task automatic end_check(input string tag, input int words, input logic done,
                             input logic err, input logic hold);
        repeat (40) @(posedge clk);
        @(negedge clk);
        check({tag, "_pending_writes"}, 64'(exp_q.size()), 64'd0);
        check({tag, "_words_loaded"}, 64'(words_loaded), 64'(words));
        check({tag, "_load_done"}, 64'(load_done), 64'(done));
        check({tag, "_load_error"}, 64'(load_error), 64'(err));
        check({tag, "_cpu_hold"}, 64'(cpu_hold), 64'(hold));
    endtask

    initial begin
        rst = 1'b1;
        rx  = 1'b1;

        // Two-word image
        do_reset();
        push_write(12'd0, 32'hDEADBEEF);
        push_write(12'd1, 32'h0000002A);
        seq = '{8'hA5, 8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h00, 8'h00, 8'h00, 8'h2A};
        send_seq();
        end_check("two_word", 2, 1'b1, 1'b0, 1'b0);

        // Garbage ahead of the sync byte
        do_reset();
        push_write(12'd0, 32'h12345678);
        seq = '{8'h00, 8'hFF, 8'h13, 8'hA5, 8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78};
        send_seq();
        end_check("garbage", 1, 1'b1, 1'b0, 1'b0);

        // Framing error mid-word, later traffic ignored
        do_reset();
        seq = '{8'hA5, 8'h00, 8'h01, 8'h11};
        send_seq();
        send_byte(8'h22, 1'b0);
        repeat (20) @(posedge clk);
        seq = '{8'h33, 8'h44, 8'hA5, 8'h00, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04};
        send_seq();
        end_check("frame_err", 0, 1'b0, 1'b1, 1'b1);

        // Short glitch followed by a zero-length image
        do_reset();
        rx = 1'b0;
        repeat (3) @(posedge clk);
        rx = 1'b1;
        repeat (20) @(posedge clk);
        seq = '{8'hA5, 8'h00, 8'h00};
        send_seq();
        end_check("glitch_zero_len", 0, 1'b1, 1'b0, 1'b0);

        // Reset in the middle of a word, then a clean image
        do_reset();
        seq = '{8'hA5, 8'h00, 8'h01, 8'hAA, 8'hBB};
        send_seq();
        repeat (5) @(posedge clk);
        do_reset();
        push_write(12'd0, 32'h01020304);
        seq = '{8'hA5, 8'h00, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04};
        send_seq();
        end_check("reset_mid_word", 1, 1'b1, 1'b0, 1'b1 ^ 1'b1);

        // Length boundary: 4096 words is accepted, 4097 is rejected
        do_reset();
        seq = '{8'hA5, 8'h10, 8'h00};
        send_seq();
        end_check("len_max", 0, 1'b0, 1'b0, 1'b1);
        do_reset();
        seq = '{8'hA5, 8'h10, 8'h01};
        send_seq();
        end_check("len_over", 0, 1'b0, 1'b1, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_program_loader.md
Name: uart_program_loader

Overview:
- Serial boot loader for the MIPS core.
- Receives a framed program image over an 8N1 UART line and writes it word by word into instruction/data memory starting at address 0.
- Holds the CPU in reset (cpu_hold) until the image is complete.
- Sits in master between the board RX pin and the memory write port, replacing simulation-only memory preload.

Parameters:
- CLK_FREQ, 50_000_000: external_clk frequency in Hz.
- BAUD, 115_200: UART bit rate.
- ADDR_WIDTH, 12: word address width (4096-word memory).
- CLKS_PER_BIT, CLK_FREQ/BAUD: derived, not overridden. Elaboration error if < 4.

Ports:
- external_clk, input, 1: system clock.
- rst, input, 1: asynchronous, active-high reset.
- rx, input, 1: UART serial in, idle high, asynchronous to external_clk.
- mem_we, output, 1: one-cycle memory write strobe.
- mem_addr, output, ADDR_WIDTH: word address of write.
- mem_wdata, output, 32: word to write.
- cpu_hold, output, 1: keeps CPU in reset while high.
- load_done, output, 1: image fully written (sticky).
- load_error, output, 1: framing/length error (sticky).
- words_loaded, output, ADDR_WIDTH+1: count of words written.

Behaviour:
- Reset is asynchronous, active-high. All state clears on assertion. Outputs at reset: mem_we=0, mem_addr=0, mem_wdata=0, cpu_hold=1, load_done=0, load_error=0, words_loaded=0.
- rx passes through a 2-flop synchronizer, reset to 1.
- Byte receiver:
  - Falling edge of synced rx starts a frame.
  - After CLKS_PER_BIT/2 cycles, rx is rechecked. If high, the event is a glitch and the receiver returns to idle.
  - Then 8 data bits are sampled LSB first, one every CLKS_PER_BIT cycles, then the stop bit.
  - Stop=1 produces a 1-cycle byte_valid with the byte.
  - Stop=0 produces a 1-cycle frame_err.
- Image format: sync byte 0xA5, length hi, length lo (word count N, big-endian), then N words of 4 bytes each, MSB first.
- Loader FSM:
  - WAIT_SYNC: bytes other than 0xA5 are discarded. 0xA5 -> LEN_HI.
  - LEN_HI -> LEN_LO on byte.
  - LEN_LO:
    - N=0 -> DONE.
    - N > 2^ADDR_WIDTH -> ERROR.
    - Otherwise -> DATA with byte_idx=0.
  - DATA:
    - Each byte shifts into the word register; byte_idx increments.
    - On the 4th byte, the next cycle drives mem_we=1 with mem_addr=word count and mem_wdata=assembled word, then words_loaded increments.
    - When words_loaded reaches N -> DONE; otherwise byte_idx=0 and the FSM stays in DATA.
  - DONE: cpu_hold=0, load_done=1. Further rx activity is ignored. The block stays in DONE until rst.
  - ERROR: load_error=1, cpu_hold stays 1, mem_we is never asserted. The block stays in ERROR until rst.
- frame_err in any state other than DONE/ERROR -> ERROR.
- mem_addr holds its last value between strobes. mem_we is never high two consecutive cycles.
- Address does not wrap: the max-length image writes addresses 0..2^ADDR_WIDTH-1 exactly once.
- rst asserted mid-byte or mid-word: partial word discarded, no write issued, FSM restarts in WAIT_SYNC.
- Latency: mem_we asserts 1 cycle after the stop-bit sample of the 4th byte. cpu_hold falls on the same edge as the final mem_we deasserting.

Decomposition:
- Package loader_pkg holds:
  - SYNC_BYTE = 8'hA5.
  - The loader state enum: WAIT_SYNC, LEN_HI, LEN_LO, DATA, DONE, ERROR.
  - The receiver state enum: IDLE, START, BITS, STOP.
- One sub-module, uart_rx_byte: synchronizer, baud counter, outputs byte_valid/byte/frame_err.
- The loader FSM and word assembly stay in uart_program_loader.

Test Plan:
All scenarios use CLK_FREQ=1_000_000 and BAUD=100_000 (10 clks/bit).
- Reset values: hold rst 3 cycles with rx=1. Outputs match reset values; cpu_hold=1.
- Two-word image: send A5 00 02 DE AD BE EF 00 00 00 2A.
  - mem_we pulses with addr 0 data 32'hDEADBEEF, then addr 1 data 32'h0000002A.
  - words_loaded=2, load_done=1, cpu_hold=0.
- Garbage before sync: send 00 FF 13 then A5 00 01 12 34 56 78.
  - Exactly one write: addr 0 data 32'h12345678.
- Framing error: send A5 00 01 11, then a byte with stop bit 0.
  - load_error=1, no mem_we, cpu_hold=1.
  - Further bytes are ignored.
- Glitch and zero length:
  - A 3-cycle low pulse on rx produces no byte.
  - Then A5 00 00 gives load_done=1 with zero writes.
- Reset mid-word: send A5 00 01 AA BB, assert rst, then send A5 00 01 01 02 03 04.
  - Single write: addr 0 data 32'h01020304.
